// File: rtl/inst_encoder.sv
// inst_encoder: packs field-level RV32I requests into machine words and writes them to consecutive imem addresses
module inst_encoder #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fmt,
    input  logic [6:0]        req_opcode,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    input  logic              req_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    typedef enum logic [1:0] {IDLE, ENCODE, WRITE, DONE} state_t;
    state_t state_q, state_d;
    logic [2:0]        fmt_q, fmt_d;
    logic [6:0]        opcode_q, opcode_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [6:0]        funct7_q, funct7_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [31:0]       imm_q, imm_d;
    logic              last_q, last_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              fresh_q, fresh_d;
    logic [31:0]       word;
    logic              bad;
    logic              is_shift;
    logic              fits12;
    logic              fits13;
    logic              fits21;
    assign is_shift = fmt_q == 3'd1 && opcode_q == 7'h13 && funct3_q[1:0] == 2'b01;
    assign fits12   = &imm_q[31:11] || ~|imm_q[31:11];
    assign fits13   = &imm_q[31:12] || ~|imm_q[31:12];
    assign fits21   = &imm_q[31:20] || ~|imm_q[31:20];
    always_comb begin
        word = '0;
        bad  = 1'b0;
        case (fmt_q)
            3'd0: word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
            3'd1: begin
                word = is_shift ? {funct7_q, imm_q[4:0], rs1_q, funct3_q, rd_q, opcode_q}
                                : {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
                bad  = is_shift ? |imm_q[31:5] : !fits12;
            end
            3'd2: begin
                word = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
                bad  = !fits12;
            end
            3'd3: begin
                word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q, imm_q[4:1], imm_q[11], opcode_q};
                bad  = !fits13 || imm_q[0];
            end
            3'd4: begin
                word = {imm_q[31:12], rd_q, opcode_q};
                bad  = |imm_q[11:0];
            end
            3'd5: begin
                word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode_q};
                bad  = !fits21 || imm_q[0];
            end
            default: bad = 1'b1;
        endcase
    end
    always_comb begin
        state_d  = state_q;
        fmt_d    = fmt_q;
        opcode_d = opcode_q;
        funct3_d = funct3_q;
        funct7_d = funct7_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        last_d   = last_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        we_d     = we_q;
        err_d    = err_q;
        count_d  = count_q;
        fresh_d  = fresh_q;
        case (state_q)
            IDLE: if (req_valid) begin
                fmt_d    = req_fmt;
                opcode_d = req_opcode;
                funct3_d = req_funct3;
                funct7_d = req_funct7;
                rd_d     = req_rd;
                rs1_d    = req_rs1;
                rs2_d    = req_rs2;
                imm_d    = req_imm;
                last_d   = req_last;
                count_d  = fresh_q ? '0 : count_q;
                err_d    = fresh_q ? 1'b0 : err_q;
                fresh_d  = 1'b0;
                state_d  = ENCODE;
            end
            ENCODE: begin
                wdata_d = word;
                addr_d  = count_q[ADDR_W-1:0];
                we_d    = !(bad || count_q[ADDR_W]);
                state_d = WRITE;
            end
            WRITE: begin
                we_d    = 1'b0;
                count_d = we_q ? count_q + (ADDR_W+1)'(1) : count_q;
                err_d   = err_q || !we_q;
                state_d = last_q ? DONE : IDLE;
            end
            default: begin
                fresh_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            fmt_q    <= '0;
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            last_q   <= 1'b0;
            wdata_q  <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
            fresh_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fmt_q    <= fmt_d;
            opcode_q <= opcode_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            last_q   <= last_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            err_q    <= err_d;
            count_q  <= count_d;
            fresh_q  <= fresh_d;
        end
    end
    assign req_ready = state_q == IDLE;
    assign done      = state_q == DONE;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign count     = count_q;
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: scoreboard bench for inst_encoder, plus a 4-word instance for the memory-full case
module tb_inst_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_fmt;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        req_last;
    logic        req_ready, mem_we, done, err;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [14:0] count;
    logic        ready_b, we_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;
    always #5 clk = ~clk;
    inst_encoder #(.ADDR_W(14)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_last(req_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .err(err), .count(count)
    );
    inst_encoder #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b),
        .req_fmt(req_fmt), .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_last(req_last),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .done(done_b), .err(err_b), .count(count_b)
    );
    typedef struct {int addr; logic [31:0] data;} exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int vectors = 0, miscompares = 0;
    int exp_cnt = 0, exp_err = 0, exp_done = 0, done_seen = 0;
    int b_cnt = 0, b_err = 0, b_done = 0, done_seen_b = 0;
    bit fresh = 0, fresh_b = 0, b_on = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (done) done_seen++;
        if (b_on && done_b) done_seen_b++;
        if (mem_we) begin
            if (qa.size() == 0) check("unexpected_we", 1, 0);
            else begin
                ea = qa.pop_front();
                check("addr", 32'(mem_addr), ea.addr);
                check("wdata", mem_wdata, ea.data);
            end
        end
        if (b_on && we_b) begin
            if (qb.size() == 0) check("unexpected_we_b", 1, 0);
            else begin
                eb = qb.pop_front();
                check("addr_b", 32'(addr_b), eb.addr);
                check("wdata_b", wdata_b, eb.data);
            end
        end
    end
    task automatic expect_req(input bit ok, input bit last, input logic [31:0] word);
        if (fresh) begin exp_cnt = 0; exp_err = 0; fresh = 0; end
        if (ok && exp_cnt < 16384) begin qa.push_back('{exp_cnt, word}); exp_cnt++; end
        else exp_err = 1;
        if (last) begin fresh = 1; exp_done++; end
        if (b_on) begin
            if (fresh_b) begin b_cnt = 0; b_err = 0; fresh_b = 0; end
            if (ok && b_cnt < 4) begin qb.push_back('{b_cnt, word}); b_cnt++; end
            else b_err = 1;
            if (last) begin fresh_b = 1; b_done++; end
        end
    endtask
    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input bit last);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check("ready_wait", 32'(n < 20), 1);
        req_fmt = fmt; req_opcode = op; req_funct3 = f3; req_funct7 = f7;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_last = last;
        req_valid = 1'b1;
    endtask
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input bit last, input bit ok, input logic [31:0] word);
        int n;
        drive(fmt, op, f3, f7, rd, rs1, rs2, imm, last);
        expect_req(ok, last, word);
        @(negedge clk);
        req_valid = 1'b0;
        req_fmt = 3'($urandom); req_imm = $urandom; req_rd = 5'($urandom); req_last = 1'($urandom);
        n = 1;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check("latency", n, last ? 4 : 3);
        check("count", 32'(count), exp_cnt);
        check("err", 32'(err), exp_err);
        check("done_pulses", done_seen, exp_done);
        if (b_on) begin
            check("count_b", 32'(count_b), b_cnt);
            check("err_b", 32'(err_b), b_err);
            check("done_pulses_b", done_seen_b, b_done);
        end
    endtask
    task automatic check_reset();
        check("rst_ready", 32'(req_ready), 1);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_count", 32'(count), 0);
        check("rst_count_b", 32'(count_b), 0);
        check("rst_err_b", 32'(err_b), 0);
    endtask
    task automatic reset_mid(input int stage);
        if (stage > 0) begin
            drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd9, 1'b0);
            if (stage == 2) expect_req(1, 0, 32'h00900393);
            @(negedge clk);
            req_valid = 1'b0;
            if (stage == 2) @(negedge clk);
        end else @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        check_reset();
        exp_cnt = 0; exp_err = 0; fresh = 0;
        b_cnt = 0; b_err = 0; fresh_b = 0;
        repeat (4) @(negedge clk);
        check("post_rst_count", 32'(count), 0);
        check("post_rst_ready", 32'(req_ready), 1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        rst = 1'b1; req_valid = 1'b0; req_fmt = '0; req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset();
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1, 1, 32'h00500093);
        send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 1, 1, 32'h002081B3);
        send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, -32'sd8, 0, 1, 32'hFE208CE3);
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 0, 32'h0);
        send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 1, 32'h001000EF);
        send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, -32'sd7, 0, 0, 32'h0);
        send(3'd1, 7'h13, 3'd1, 7'h00, 5'd5, 5'd5, 5'd0, 32'd3, 0, 1, 32'h00329293);
        send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345001, 0, 0, 32'h0);
        send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 0, 1, 32'h123452B7);
        send(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0, 0, 0, 32'h0);
        send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, -32'sd4, 0, 1, 32'hFE20AE23);
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, -32'sd2048, 0, 1, 32'h80000093);
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2047, 0, 1, 32'h7FF00093);
        send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094, 0, 1, 32'h7E000FE3);
        send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, -32'sd4096, 0, 1, 32'h80000063);
        send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4096, 0, 0, 32'h0);
        send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, -32'sd1048576, 0, 1, 32'h8000006F);
        send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd1048576, 0, 0, 32'h0);
        send(3'd1, 7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd32, 0, 0, 32'h0);
        send(3'd1, 7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd31, 1, 1, 32'h41F0D093);
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd1, 0, 1, 32'h00100113);
        send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 0, 1, 32'h002081B3);
        send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 1, 1, 32'h0000006F);
        reset_mid(1);
        reset_mid(2);
        reset_mid(0);
        b_on = 1'b1;
        for (int k = 1; k <= 5; k++)
            send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'(k), k == 5, 1, (32'(k) << 20) | 32'h93);
        repeat (4) @(negedge clk);
        check("queue_empty", 32'(qa.size()), 0);
        check("queue_empty_b", 32'(qb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
